norm_shift_ctrl: RTL and testbench

Controller that sequences a pair of 16-bit left-shift registers (operands A and B) to normalize both operands, shifting each left until its MSB is 1. It is a start/done handshake block. It issues the parallel-load and shift-enable controls, watches each register's MSB, and counts the shifts applied per lane. The counts feed the downstream 32-bit product alignment stage, which is shifted back by cnt_a + cnt_b.

---
 rtl/norm_pkg.sv | 13 +
 rtl/norm_lane.sv | 52 +++++
 rtl/norm_shift_ctrl.sv | 87 ++++++++
 tb/tb_norm_shift_ctrl.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/norm_pkg.sv
// Shared types and defaults for the operand normalization controller.
package norm_pkg;
   localparam int W_DEF     = 16;
   localparam int CNT_W_DEF = 4;
   localparam int NUM_LANES = 2;   // lane 0 = A, lane 1 = B

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } state_t;
endpackage

// File: rtl/norm_lane.sv
// One normalization lane: shift enable, saturating shift counter, zero flag.
// NORM_ZERO_DETECT_EN: a zero operand is held unshifted and flagged.
module norm_lane
   import norm_pkg::*;
#(
   parameter int W     = W_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             active,
   input  logic             msb,
   input  logic             zero,
   output logic             shift_en,
   output logic [CNT_W-1:0] cnt,
   output logic             zflag
);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(W - 1);

   logic stop;

`ifdef NORM_ZERO_DETECT_EN
   assign stop = zero;

   // zflag latches a zero operand seen while shifting; cleared on load
   always_ff @(posedge clk) begin
      if (rst || clr)
         zflag <= 1'b0;
      else if (active && zero)
         zflag <= 1'b1;
   end
`else
   logic unused_zero;
   assign unused_zero = zero;
   assign stop        = 1'b0;
   assign zflag       = 1'b0;
`endif

   // shift until MSB set, count saturated, or lane stopped by zero detect
   always_comb begin
      shift_en = active && !msb && (cnt != CNT_MAX) && !stop;
   end

   // saturating shift counter, cleared on load
   always_ff @(posedge clk) begin
      if (rst || clr)
         cnt <= '0;
      else if (shift_en && (cnt != CNT_MAX))
         cnt <= cnt + CNT_W'(1);
   end
endmodule

// File: rtl/norm_shift_ctrl.sv
// Start/done controller normalizing two left-shift registers (A, B).
// Optional build macro NORM_ZERO_DETECT_EN enables zero-operand detection.
module norm_shift_ctrl
   import norm_pkg::*;
#(
   parameter int W     = W_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             msb_a,
   input  logic             msb_b,
   input  logic             zero_a,
   input  logic             zero_b,
   output logic             ld_ab,
   output logic             shift_en_a,
   output logic             shift_en_b,
   output logic [CNT_W-1:0] cnt_a,
   output logic [CNT_W-1:0] cnt_b,
   output logic             zflag_a,
   output logic             zflag_b,
   output logic             busy,
   output logic             done
);
   state_t state, state_nxt;

   logic [NUM_LANES-1:0]            msb_v, zero_v, sen_v, zf_v;
   logic [NUM_LANES-1:0][CNT_W-1:0] cnt_v;
   logic                            in_load, in_shift;

   assign msb_v  = {msb_b, msb_a};
   assign zero_v = {zero_b, zero_a};

   assign in_load  = (state == LOAD);
   assign in_shift = (state == SHIFT);

   for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      norm_lane #(.W(W), .CNT_W(CNT_W)) u_lane (
         .clk      (clk),
         .rst      (rst),
         .clr      (in_load),
         .active   (in_shift),
         .msb      (msb_v[i]),
         .zero     (zero_v[i]),
         .shift_en (sen_v[i]),
         .cnt      (cnt_v[i]),
         .zflag    (zf_v[i])
      );
   end

   assign shift_en_a = sen_v[0];
   assign shift_en_b = sen_v[1];
   assign cnt_a      = cnt_v[0];
   assign cnt_b      = cnt_v[1];
   assign zflag_a    = zf_v[0];
   assign zflag_b    = zf_v[1];

   // state register
   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // next state and control strobes decoded from current state
   always_comb begin
      state_nxt = state;
      ld_ab     = 1'b0;
      done      = 1'b0;
      busy      = (state != IDLE);
      case (state)
         IDLE:  if (start) state_nxt = LOAD;
         LOAD:  begin
            ld_ab     = 1'b1;
            state_nxt = SHIFT;
         end
         SHIFT: if (sen_v == '0) state_nxt = DONE;
         DONE:  begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end
endmodule

// File: tb/tb_norm_shift_ctrl.sv
// Directed bench for norm_shift_ctrl with a behavioural model of the A/B shift registers.
module tb_norm_shift_ctrl;
   localparam int W = 16;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst, start;
   logic          msb_a, msb_b, zero_a, zero_b;
   logic          ld_ab, shift_en_a, shift_en_b, zflag_a, zflag_b, busy, done;
   logic [CW-1:0] cnt_a, cnt_b;

   logic [W-1:0]  va, vb, ra, rb;
   int            nchk = 0, nfail = 0;

   always #5 clk = ~clk;

   norm_shift_ctrl #(.W(W), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .start(start),
      .msb_a(msb_a), .msb_b(msb_b), .zero_a(zero_a), .zero_b(zero_b),
      .ld_ab(ld_ab), .shift_en_a(shift_en_a), .shift_en_b(shift_en_b),
      .cnt_a(cnt_a), .cnt_b(cnt_b), .zflag_a(zflag_a), .zflag_b(zflag_b),
      .busy(busy), .done(done)
   );

   // external operand registers: parallel load, then left shift on enable
   always @(posedge clk) begin
      if (ld_ab) begin
         ra <= va;
         rb <= vb;
      end else begin
         if (shift_en_a) ra <= ra << 1;
         if (shift_en_b) rb <= rb << 1;
      end
   end

   assign msb_a  = ra[W-1];
   assign msb_b  = rb[W-1];
   assign zero_a = (ra == '0);
   assign zero_b = (rb == '0);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nchk++;
      if (obs !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // one start/done transaction; on return the block is in the IDLE cycle after done
   task automatic run(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                      input int exp_ca, input int exp_cb, input int exp_za, input int exp_zb);
      int cyc, done_cyc, n_sa, n_sb, n_ld, n_both;
      va = a;
      vb = b;
      start = 1'b1;
      tick();                    // edge 0 samples start
      start = 1'b0;
      cyc = 1; done_cyc = -1; n_sa = 0; n_sb = 0; n_ld = 0; n_both = 0;
      chk({tag, ".ld_c1"}, 32'(ld_ab), 32'd1);
      chk({tag, ".busy_c1"}, 32'(busy), 32'd1);
      while (cyc < 40 && done_cyc < 0) begin
         if (shift_en_a) n_sa++;
         if (shift_en_b) n_sb++;
         if (ld_ab) n_ld++;
         if (ld_ab && (shift_en_a || shift_en_b)) n_both++;
         if (done) done_cyc = cyc;
         else begin
            tick();
            cyc++;
         end
      end
      chk({tag, ".done_cyc"}, 32'(done_cyc), 32'(3 + ((exp_ca > exp_cb) ? exp_ca : exp_cb)));
      chk({tag, ".cnt_a"}, 32'(cnt_a), 32'(exp_ca));
      chk({tag, ".cnt_b"}, 32'(cnt_b), 32'(exp_cb));
      chk({tag, ".zflag_a"}, 32'(zflag_a), 32'(exp_za));
      chk({tag, ".zflag_b"}, 32'(zflag_b), 32'(exp_zb));
      chk({tag, ".n_sh_a"}, 32'(n_sa), 32'(exp_ca));
      chk({tag, ".n_sh_b"}, 32'(n_sb), 32'(exp_cb));
      chk({tag, ".n_ld"}, 32'(n_ld), 32'd1);
      chk({tag, ".ld_sh_overlap"}, 32'(n_both), 32'd0);
      tick();                    // IDLE cycle after done
      chk({tag, ".busy_after"}, 32'(busy), 32'd0);
      chk({tag, ".done_after"}, 32'(done), 32'd0);
      chk({tag, ".cnt_a_hold"}, 32'(cnt_a), 32'(exp_ca));
   endtask

   initial begin
      int n_ld, n_done, n_dn;
      rst = 1'b1; start = 1'b0; va = '0; vb = '0;
      ra = '0; rb = '0;
      tick(); tick();
      chk("rst.outs", {20'd0, 4'(cnt_a), 4'(cnt_b), ld_ab, shift_en_a | shift_en_b, busy, done}, 32'd0);
      chk("rst.zflag", 32'({zflag_a, zflag_b}), 32'd0);
      rst = 1'b0;
      tick();
      chk("idle.busy", 32'(busy), 32'd0);

      run("t1", 16'h8000, 16'h4000, 0, 1, 0, 0);
      run("t2", 16'h0001, 16'h00F0, 15, 8, 0, 0);
`ifdef NORM_ZERO_DETECT_EN
      run("t3z", 16'h0000, 16'h1234, 0, 3, 1, 0);
`else
      run("t3", 16'h0000, 16'h1234, 15, 3, 0, 0);
`endif
      // back-to-back: t4 starts in the IDLE cycle right after t3's done
      run("t4", 16'h4000, 16'h2000, 1, 2, 0, 0);

      // start held high: one LOAD per IDLE visit, no reload while busy
      va = 16'h8000; vb = 16'h8000;
      start = 1'b1;
      n_ld = 0; n_done = 0;
      tick();
      for (int c = 1; c <= 8; c++) begin
         if (ld_ab) n_ld++;
         if (done) n_done++;
         tick();
      end
      start = 1'b0;
      chk("hold.n_ld", 32'(n_ld), 32'd2);
      chk("hold.n_done", 32'(n_done), 32'd2);
      while (busy) tick();

      // reset during the 5th SHIFT cycle (cycle 6)
      va = 16'h0001; vb = 16'h0001;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 1; c < 6; c++) tick();
      chk("rstmid.shifting", 32'(shift_en_a), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rstmid.outs", {20'd0, 4'(cnt_a), 4'(cnt_b), ld_ab, shift_en_a | shift_en_b, busy, done}, 32'd0);
      n_dn = 0;
      for (int c = 0; c < 20; c++) begin
         if (done || busy) n_dn++;
         tick();
      end
      chk("rstmid.no_done", 32'(n_dn), 32'd0);

      // normal run after mid-operation reset
      run("t5", 16'h0F00, 16'h8001, 4, 0, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
      $finish;
   end
endmodule
